// File: rtl/conv2_res_collector.sv
`timescale 1ns/1ps
// conv2_res_collector: packs the serial conv_2 result bits LSB-first into WORD_W-bit words,
// checks the producer index sequence, and serves the stored frame through a registered read port.
module conv2_res_collector #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned NUM_RES = 1600,
  parameter int unsigned DEPTH   = NUM_RES / WORD_W,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_res,
  input  logic [10:0]       i_count_num,
  input  logic              i_res_ok,
  input  logic              i_clear,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_done,
  output logic [10:0]       o_bit_cnt,
  output logic              o_seq_err
);

  localparam int unsigned CntW = 11;
  localparam int unsigned PosW = $clog2(WORD_W);

  typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_bit_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_seq_err;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_in_frame;
  logic              w_full;
  logic              w_accept;
  logic              w_overflow;
  logic              w_idx_err;
  logic              w_late_en;
  logic [CntW-1:0]   w_pos_full;
  logic [CntW-1:0]   w_widx_full;
  logic [PosW-1:0]   w_pos;
  logic [ADDR_W-1:0] w_widx;
  logic [WORD_W-1:0] w_word;
  logic              w_word_done;
  logic              w_flush_wr;
  logic              w_mem_we;
  logic [WORD_W-1:0] w_mem_wdata;

  assign w_in_frame  = (r_state == StIdle) || (r_state == StCollect);
  assign w_full      = (r_bit_cnt == CntW'(NUM_RES));
  assign w_accept    = i_en && w_in_frame && !i_clear && !w_full;
  assign w_overflow  = i_en && w_in_frame && w_full;
  // The bit is stored at the bit_cnt position even when the index disagrees.
  assign w_idx_err   = w_accept && (i_count_num != r_bit_cnt);
  assign w_late_en   = i_en && (r_state == StDone);
  assign w_pos_full  = r_bit_cnt % CntW'(WORD_W);
  assign w_widx_full = r_bit_cnt / CntW'(WORD_W);
  assign w_pos       = w_pos_full[PosW-1:0];
  assign w_widx      = w_widx_full[ADDR_W-1:0];
  assign w_word_done = w_accept && (w_pos_full == CntW'(WORD_W - 1));
  assign w_flush_wr  = (r_state == StFlush) && !i_clear && (w_pos_full != '0);
  assign w_mem_we    = w_word_done || w_flush_wr;
  // Unwritten upper bits of the shift word are already zero, giving the flush padding.
  assign w_mem_wdata = w_word_done ? w_word : r_shift;

  // Shift word with the incoming bit merged at its position
  always_comb begin
    w_word        = r_shift;
    w_word[w_pos] = i_res;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_en)          w_state_next = i_res_ok ? StFlush : StCollect;
        else if (i_res_ok) w_state_next = StDone;
      end
      StCollect: if (i_res_ok) w_state_next = StFlush;
      StFlush:   w_state_next = StDone;
      StDone:    w_state_next = StDone;
      default:   w_state_next = StIdle;
    endcase
    if (i_clear) w_state_next = StIdle;
  end

  // FSM outputs
  always_comb begin
    o_done = (r_state == StDone);
  end

  // Bit counter, shift word and sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_seq_err <= 1'b0;
    end else if (i_clear) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_seq_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bit_cnt <= r_bit_cnt + CntW'(1);
        r_shift   <= w_word_done ? '0 : w_word;
      end
      if (w_idx_err || w_overflow || w_late_en) r_seq_err <= 1'b1;
    end
  end

  // Word buffer, no reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_widx] <= w_mem_wdata;
  end

  // Registered read port, live only once the frame is stored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (i_rd_en && (r_state == StDone)) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= (32'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_seq_err  = r_seq_err;

endmodule

// File: tb/tb_conv2_res_collector.sv
`timescale 1ns/1ps
// Directed bench for conv2_res_collector with hand-computed expectations.
module tb_conv2_res_collector;

  localparam int unsigned WordW  = 16;
  localparam int unsigned NumRes = 1600;
  localparam int unsigned Depth  = 100;
  localparam int unsigned AddrW  = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             res;
  logic [10:0]      count_num;
  logic             res_ok;
  logic             clear;
  logic             rd_en;
  logic [AddrW-1:0] rd_addr;
  logic [WordW-1:0] rd_data;
  logic             rd_valid;
  logic             done;
  logic [10:0]      bit_cnt;
  logic             seq_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv2_res_collector #(
    .WORD_W (WordW),
    .NUM_RES(NumRes),
    .DEPTH  (Depth),
    .ADDR_W (AddrW)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_res      (res),
    .i_count_num(count_num),
    .i_res_ok   (res_ok),
    .i_clear    (clear),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_done     (done),
    .o_bit_cnt  (bit_cnt),
    .o_seq_err  (seq_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // mode 0: res = index LSB, 1: all ones, 2: all zeros; sparse adds idle gaps
  task automatic send_bits(input int first, input int n, input int mode, input bit sparse);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx       = first + i;
      en        = 1'b1;
      count_num = 11'(idx);
      res       = (mode == 0) ? idx[0] : (mode == 1);
      tick();
      en = 1'b0;
      if (sparse) repeat (2 + $urandom_range(0, 3)) tick();
    end
  endtask

  // res_ok one cycle after the last bit, then FLUSH, then DONE
  task automatic finish_frame(input string tag);
    res_ok = 1'b1;
    tick();
    res_ok = 1'b0;
    check_eq({tag, "_done_flush"}, 32'(done), 32'd0);
    tick();
    check_eq({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Back-to-back reads of every word, then confirm the valid pulse ends
  task automatic read_all(input string tag, input logic [WordW-1:0] exp);
    for (int a = 0; a < int'(Depth); a++) begin
      rd_en   = 1'b1;
      rd_addr = AddrW'(a);
      tick();
      check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(rd_data), 32'(exp));
    end
    rd_en = 1'b0;
    tick();
    check_eq({tag, "_valid_end"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic read_one(input string tag, input int addr, input logic [WordW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = AddrW'(addr);
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    res       = 1'b0;
    count_num = '0;
    res_ok    = 1'b0;
    clear     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    #1;
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check_eq("rst_seq_err", 32'(seq_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Read in IDLE is not serviced
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Full frame, alternating bits -> 0xAAAA everywhere
    send_bits(0, NumRes, 0, 1'b0);
    check_eq("full_bit_cnt", 32'(bit_cnt), 32'd1600);
    finish_frame("full");
    check_eq("full_seq_err", 32'(seq_err), 32'd0);
    read_all("full_rd", 16'hAAAA);

    // Sparse version of the same frame
    do_clear();
    check_eq("clr_done", 32'(done), 32'd0);
    send_bits(0, NumRes, 0, 1'b1);
    finish_frame("sparse");
    check_eq("sparse_seq_err", 32'(seq_err), 32'd0);
    check_eq("sparse_bit_cnt", 32'(bit_cnt), 32'd1600);
    read_all("sparse_rd", 16'hAAAA);

    // 1601st bit is dropped and flagged
    do_clear();
    send_bits(0, NumRes, 0, 1'b0);
    check_eq("ovf_seq_err_pre", 32'(seq_err), 32'd0);
    en        = 1'b1;
    count_num = 11'd1600;
    res       = 1'b1;
    tick();
    en = 1'b0;
    check_eq("ovf_seq_err", 32'(seq_err), 32'd1);
    check_eq("ovf_bit_cnt", 32'(bit_cnt), 32'd1600);

    // clear at bit 500 wins over en, then an all-zero frame
    do_clear();
    send_bits(0, 500, 0, 1'b0);
    check_eq("mid_bit_cnt_pre", 32'(bit_cnt), 32'd500);
    en        = 1'b1;
    clear     = 1'b1;
    count_num = 11'd500;
    res       = 1'b1;
    tick();
    en    = 1'b0;
    clear = 1'b0;
    check_eq("mid_clr_bit_cnt", 32'(bit_cnt), 32'd0);
    check_eq("mid_clr_done", 32'(done), 32'd0);
    send_bits(0, NumRes, 2, 1'b0);
    finish_frame("zero");
    check_eq("zero_seq_err", 32'(seq_err), 32'd0);
    read_all("zero_rd", 16'h0000);

    // Index jump 5 -> 7 sets the sticky error
    do_clear();
    send_bits(0, 6, 0, 1'b0);
    check_eq("idx_seq_err_pre", 32'(seq_err), 32'd0);
    en        = 1'b1;
    count_num = 11'd7;
    res       = 1'b1;
    tick();
    en = 1'b0;
    check_eq("idx_seq_err", 32'(seq_err), 32'd1);
    check_eq("idx_bit_cnt", 32'(bit_cnt), 32'd7);
    finish_frame("idx");
    check_eq("idx_seq_err_done", 32'(seq_err), 32'd1);
    en = 1'b1;
    tick();
    en = 1'b0;
    check_eq("idx_done_en_cnt", 32'(bit_cnt), 32'd7);
    do_clear();
    check_eq("idx_seq_err_clr", 32'(seq_err), 32'd0);

    // Partial frame: 20 ones, res_ok with the last bit
    send_bits(0, 19, 1, 1'b0);
    en        = 1'b1;
    count_num = 11'd19;
    res       = 1'b1;
    res_ok    = 1'b1;
    tick();
    en     = 1'b0;
    res_ok = 1'b0;
    check_eq("part_done_flush", 32'(done), 32'd0);
    tick();
    check_eq("part_done", 32'(done), 32'd1);
    check_eq("part_bit_cnt", 32'(bit_cnt), 32'd20);
    check_eq("part_seq_err", 32'(seq_err), 32'd0);
    read_one("part_rd120", 120, 16'h0000);
    read_one("part_rd1", 1, 16'h000F);
    read_one("part_rd0", 0, 16'hFFFF);
    tick();
    check_eq("part_valid_pulse", 32'(rd_valid), 32'd0);

    // Asynchronous reset in the middle of a frame
    do_clear();
    send_bits(0, 300, 0, 1'b0);
    en        = 1'b1;
    count_num = 11'd999;
    tick();
    en = 1'b0;
    check_eq("arst_seq_err_pre", 32'(seq_err), 32'd1);
    check_eq("arst_bit_cnt_pre", 32'(bit_cnt), 32'd301);
    check_eq("arst_rd_data_pre", 32'(rd_data), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rd_data", 32'(rd_data), 32'd0);
    check_eq("arst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_bit_cnt", 32'(bit_cnt), 32'd0);
    check_eq("arst_seq_err", 32'(seq_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("arst_idle_rd_valid", 32'(rd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
